// File: rtl/rst_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | rst_sequencer_pkg : state encodings and shared constants for rst_sequencer |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  // Counter width able to hold n-1 without wrapping; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// +--------------------------------------------------------------------------+
// | sync_ff : N-stage single-bit synchronizer, async active-high reset        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_sequencer.sv
// +--------------------------------------------------------------------------+
// | rst_sequencer : lock-qualified CPU reset with button debounce and         |
// |                 loss-of-lock recording. Revision 1.0                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int DEBOUNCE_CYCLES    = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       btn_rst,
  output logic       rst_out,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HOLD_W   = cnt_width(HOLD_CYCLES);
  localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  logic                locked_s;
  logic                btn_s;
  logic                btn_db;
  logic                btn_db_q;
  logic [DB_W-1:0]     db_cnt;
  logic                press;

  state_t              state;
  state_t              next_state;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_rst),
    .q   (btn_s)
  );

  // Debounced level only follows btn_s after it has differed for a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= next_state;
      stable_cnt <= stable_next;
      hold_cnt   <= hold_next;
    end
  end

  always_comb begin
    next_state  = state;
    stable_next = stable_cnt;
    hold_next   = hold_cnt;
    // Loss of lock overrides everything, including a same-cycle press.
    if (!locked_s) begin
      next_state  = S_WAIT_LOCK;
      stable_next = '0;
      hold_next   = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          next_state  = S_STABLE;
          stable_next = '0;
          hold_next   = '0;
        end
        S_STABLE: begin
          if (stable_cnt == STABLE_LAST) begin
            next_state  = S_HOLD;
            stable_next = '0;
            hold_next   = '0;
          end else begin
            stable_next = stable_cnt + STABLE_W'(1);
          end
        end
        S_HOLD: begin
          if (press || btn_db) begin
            hold_next = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            next_state = S_RUN;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (press) begin
            next_state = S_HOLD;
            hold_next  = '0;
          end
        end
        default: begin
          next_state  = S_WAIT_LOCK;
          stable_next = '0;
          hold_next   = '0;
        end
      endcase
    end
  end

  // Outputs track next_state so rst_out changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      rst_out <= (next_state != S_RUN);
      ready   <= (next_state == S_RUN);
      if ((state == S_RUN) && !locked_s) begin
        lock_lost <= 1'b1;
        if (lock_loss_cnt != LOSS_CNT_MAX) begin
          lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rst_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_rst_sequencer : directed scoreboard bench for rst_sequencer            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rst_sequencer;
  import rst_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       btn_rst = 1'b0;
  logic       rst_out;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;

  rst_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (4),
    .HOLD_CYCLES        (8),
    .DEBOUNCE_CYCLES    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .btn_rst       (btn_rst),
    .rst_out       (rst_out),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          at;
    logic [10:0] exp;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  logic model_lost = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {rst_out, ready, lock_lost, lock_loss_cnt} after edge 'at'.
  task automatic push(input string tag, input int at, input logic ro,
                      input logic lost, input logic [7:0] cnt);
    sb_t e;
    e.tag = tag;
    e.at  = at;
    e.exp = {ro, ~ro, lost, cnt};
    sb.push_back(e);
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check(e.tag, {21'b0, rst_out, ready, lock_lost, lock_loss_cnt}, {21'b0, e.exp});
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    locked  = 1'b0;
    btn_rst = 1'b0;
    #1;
    check("async_reset", {28'b0, rst_out, ready, lock_lost, lock_loss_cnt == 8'd0},
          {28'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    check("async_reset_cnt", {24'b0, lock_loss_cnt}, 32'd0);
    tick_n(3);
    rst        = 1'b0;
    model_cnt  = 0;
    model_lost = 1'b0;
  endtask

  // locked rises right after edge 'base' and stays high: rst_out falls at base+15.
  task automatic expect_seq(input string tag, input int base);
    for (int k = 1; k <= 14; k++) push(tag, base + k, 1'b1, model_lost, 8'(model_cnt));
    push(tag, base + 15, 1'b0, model_lost, 8'(model_cnt));
    push(tag, base + 16, 1'b0, model_lost, 8'(model_cnt));
  endtask

  task automatic loss_cycle(input string tag);
    int base;
    int nxt;
    base = cyc;
    nxt  = (model_cnt == 255) ? 255 : model_cnt + 1;
    push(tag, base + 1, 1'b0, model_lost, 8'(model_cnt));
    push(tag, base + 2, 1'b0, model_lost, 8'(model_cnt));
    for (int k = 3; k <= 19; k++) push(tag, base + k, 1'b1, 1'b1, 8'(nxt));
    push(tag, base + 20, 1'b0, 1'b1, 8'(nxt));
    push(tag, base + 21, 1'b0, 1'b1, 8'(nxt));
    locked = 1'b0;
    tick_n(5);
    locked = 1'b1;
    tick_n(16);
    model_cnt  = nxt;
    model_lost = 1'b1;
  endtask

  initial begin
    int base;
    int nxt;

    #2;
    // Scenario 1: power-up
    do_reset();
    base = cyc;
    expect_seq("s1_powerup", base);
    locked = 1'b1;
    tick_n(16);

    // Scenario 2: unstable first lock
    do_reset();
    base = cyc;
    for (int k = 1; k <= 19; k++) push("s2_unstable", base + k, 1'b1, 1'b0, 8'd0);
    push("s2_unstable", base + 20, 1'b0, 1'b0, 8'd0);
    push("s2_unstable", base + 21, 1'b0, 1'b0, 8'd0);
    locked = 1'b1;
    tick_n(3);
    locked = 1'b0;
    tick_n(2);
    locked = 1'b1;
    tick_n(16);

    // Scenario 3: bouncing button then a clean press
    base = cyc;
    for (int k = 1; k <= 10; k++) push("s3_bounce", base + k, 1'b0, 1'b0, 8'd0);
    base = base + 10;
    for (int k = 1; k <= 6; k++) push("s3_press", base + k, 1'b0, 1'b0, 8'd0);
    for (int k = 7; k <= 19; k++) push("s3_press", base + k, 1'b1, 1'b0, 8'd0);
    push("s3_press", base + 20, 1'b0, 1'b0, 8'd0);
    push("s3_press", base + 21, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      btn_rst = (i % 2 == 0);
      tick();
    end
    btn_rst = 1'b1;
    tick_n(6);
    btn_rst = 1'b0;
    tick_n(15);

    // Scenario 4: single loss of lock in S_RUN
    loss_cycle("s4_loss");

    // Scenario 5: press and locked_s fall land on the same edge
    base = cyc;
    nxt  = model_cnt + 1;
    for (int k = 1; k <= 6; k++) push("s5_simul", base + k, 1'b0, 1'b1, 8'(model_cnt));
    for (int k = 7; k <= 23; k++) push("s5_simul", base + k, 1'b1, 1'b1, 8'(nxt));
    push("s5_simul", base + 24, 1'b0, 1'b1, 8'(nxt));
    push("s5_simul", base + 25, 1'b0, 1'b1, 8'(nxt));
    btn_rst = 1'b1;
    tick_n(4);
    locked = 1'b0;
    tick_n(2);
    btn_rst = 1'b0;
    tick();
    check("s5_state", 32'(dut.state), 32'(S_WAIT_LOCK));
    tick_n(2);
    locked = 1'b1;
    tick_n(16);
    model_cnt = nxt;

    // Scenario 4 repeated: counter saturates at 255
    for (int i = 0; i < 256; i++) loss_cycle("s4_repeat");
    check("s4_saturated", {24'b0, lock_loss_cnt}, 32'd255);

    // Scenario 6: async reset in the middle of S_HOLD
    locked = 1'b0;
    tick_n(5);
    locked = 1'b1;
    tick_n(11);
    check("s6_in_hold", 32'(dut.state), 32'(S_HOLD));
    #2;
    rst = 1'b1;
    #1;
    check("s6_async", {21'b0, rst_out, ready, lock_lost, lock_loss_cnt},
          {21'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    tick_n(2);
    rst        = 1'b0;
    model_cnt  = 0;
    model_lost = 1'b0;
    base = cyc;
    expect_seq("s6_restart", base);
    tick_n(16);

    check("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
